// File: rtl/hex_uart_tx_pkg.sv
// Shared frame states, line-ending constants and ASCII helpers for the hex UART export path.
package hex_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam int         CHARS = 10;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Characters 0..7 are the nibbles MSB first, then CR, then LF.
  function automatic logic [7:0] char_at(input logic [31:0] word, input logic [3:0] idx);
    logic [31:0] sh;
    sh = word >> (5'd28 - {idx[2:0], 2'b00});
    if (idx < 4'd8) begin
      return nibble_to_ascii(sh[3:0]);
    end else if (idx == 4'd8) begin
      return CR;
    end else begin
      return LF;
    end
  endfunction

endpackage

// File: rtl/hex_uart_tx_byte.sv
// 8N1 byte serialiser; ready rises in the last stop-bit cycle so back-to-back bytes leave no gap.
// States: IDLE line high | START start bit | DATA 8 bits LSB first | STOP stop bit
module uart_byte_tx
  import hex_uart_tx_pkg::*;
#(
  parameter int DIVISOR = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       tx_o,
  output logic       ready_o
);

  localparam int               CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIVISOR - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (baud_q == LAST);
  assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
        end
      end
    endcase
    if (valid_i && ready_o) begin
      state_d = ST_START;
      shift_d = data_i;
      baud_d  = '0;
      bit_d   = 3'd0;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/hex_uart_tx.sv
// Sends a captured 32-bit word as 8 uppercase hex characters plus CR LF over an 8N1 UART line.
module hex_uart_tx
  import hex_uart_tx_pkg::*;
#(
  parameter int CLK_HZ  = 25000000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / BAUD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  logic        start_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic [31:0] word_q, word_d;
  logic        accept;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;

  assign accept = start && !start_q && !busy_q;
  assign busy   = busy_q;
  assign done   = done_q;

  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    char_idx_d = char_idx_q;
    word_d     = word_q;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    if (accept) begin
      // The first character comes straight from the input so its start bit leaves on the next cycle.
      word_d     = data;
      char_idx_d = 4'd0;
      busy_d     = 1'b1;
      byte_valid = 1'b1;
      byte_data  = char_at(data, 4'd0);
    end else if (busy_q && byte_ready) begin
      if (char_idx_q == 4'(CHARS - 1)) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        char_idx_d = 4'd0;
      end else begin
        char_idx_d = char_idx_q + 4'd1;
        byte_valid = 1'b1;
        byte_data  = char_at(word_q, char_idx_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      char_idx_q <= 4'd0;
      word_q     <= 32'h0;
    end else begin
      start_q    <= start;
      busy_q     <= busy_d;
      done_q     <= done_d;
      char_idx_q <= char_idx_d;
      word_q     <= word_d;
    end
  end

  uart_byte_tx #(
    .DIVISOR (DIVISOR)
  ) u_byte_tx (
    .clock   (clock),
    .reset   (reset),
    .data_i  (byte_data),
    .valid_i (byte_valid),
    .tx_o    (tx),
    .ready_o (byte_ready)
  );

endmodule

// File: tb/tb_hex_uart_tx.sv
// Scoreboard bench for hex_uart_tx: expected bytes queued on start, popped by a UART receiver model.
module tb_hex_uart_tx;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic        tx;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  hex_uart_tx #(
    .DIVISOR (DIV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .data  (data),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         rx_count = 0;
  int         done_count = 0;
  string      hexs = "0123456789ABCDEF";

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [3:0] nib;
    for (int k = 0; k < 8; k++) begin
      nib = w[(7-k)*4 +: 4];
      exp_q.push_back(hexs[int'(nib)]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_until_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) return;
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
    end
    chk("done_timeout", {31'h0, done}, 32'h1);
  endtask

  // Receiver model: samples each bit in its middle cycle.
  int         rx_state = 0;
  int         rx_cnt = 0;
  int         rx_j = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      rx_state = 0;
    end else if (rx_state == 0) begin
      if (tx === 1'b0) begin
        rx_state = 1;
        rx_cnt   = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        rx_j = rx_cnt / DIV;
        if (rx_j == 0) begin
          chk("rx_start_bit", {31'h0, tx}, 32'h0);
        end else if (rx_j <= 8) begin
          rx_byte[rx_j-1] = tx;
        end else begin
          chk("rx_stop_bit", {31'h0, tx}, 32'h1);
          rx_count++;
          if (exp_q.size() == 0) chk("rx_extra_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
          else chk("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
          rx_state = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bc;
    int         d0;
    int         r0;
    int         cnt_busy;
    int         cnt_low;
    logic [9:0] frame;

    reset = 1'b1;
    start = 1'b0;
    data  = 32'h0;
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // DEADBEEF: exact bit timing of the first character, busy length, done pulse
    data = 32'hDEADBEEF;
    push_word(data);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    frame = {1'b1, 8'h44, 1'b0};
    chk("t1_busy_rise", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 10 * DIV; i++) begin
      chk("t1_first_char_bit", {31'h0, tx}, {31'h0, frame[i/DIV]});
      @(negedge clock);
    end
    run_until_done(bc);
    chk("t1_busy_len", bc + 10 * DIV, 100 * DIV);
    chk("t1_done", {31'h0, done}, 32'h1);
    chk("t1_busy_fall", {31'h0, busy}, 32'h0);
    chk("t1_tx_idle", {31'h0, tx}, 32'h1);
    @(negedge clock);
    chk("t1_done_width", {31'h0, done}, 32'h0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // digits and letters mixed
    data = 32'h0123A9F0;
    push_word(data);
    pulse_start();
    run_until_done(bc);
    @(negedge clock);
    chk("t2_queue_empty", exp_q.size(), 0);

    // start held long: one transmission only
    r0 = rx_count;
    d0 = done_count;
    data = 32'h12345678;
    push_word(data);
    start = 1'b1;
    repeat (1000) @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("t3_held_bytes", rx_count - r0, 10);
    chk("t3_held_dones", done_count - d0, 1);

    // edge during busy ignored; edge in the done cycle accepted
    r0 = rx_count;
    d0 = done_count;
    data = 32'hCAFE0042;
    push_word(data);
    pulse_start();
    repeat (50) @(negedge clock);
    data = 32'h11111111;
    pulse_start();
    run_until_done(bc);
    data = 32'h9876FEDC;
    push_word(data);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t3_reaccept_busy", {31'h0, busy}, 32'h1);
    run_until_done(bc);
    @(negedge clock);
    chk("t3_two_tx_bytes", rx_count - r0, 20);
    chk("t3_two_tx_dones", done_count - d0, 2);

    // data change while busy has no effect
    data = 32'h00000000;
    push_word(data);
    pulse_start();
    repeat (48) @(negedge clock);
    data = 32'hFFFFFFFF;
    run_until_done(bc);
    @(negedge clock);
    chk("t4_queue_empty", exp_q.size(), 0);

    // reset mid-transmission
    data = 32'hA5A51234;
    push_word(data);
    pulse_start();
    repeat (136) @(negedge clock);
    d0 = done_count;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_tx", {31'h0, tx}, 32'h1);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    chk("t5_rst_done", {31'h0, done}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (500) @(negedge clock);
    chk("t5_no_done", done_count - d0, 0);
    r0 = rx_count;
    data = 32'h5EC0DE77;
    push_word(data);
    pulse_start();
    run_until_done(bc);
    @(negedge clock);
    chk("t5_fresh_bytes", rx_count - r0, 10);
    chk("t5_queue_empty", exp_q.size(), 0);

    // start rising with reset, then held across release
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    cnt_busy = 0;
    cnt_low  = 0;
    repeat (50) begin
      @(negedge clock);
      if (busy === 1'b1) cnt_busy++;
      if (tx !== 1'b1) cnt_low++;
    end
    chk("t6_no_busy", cnt_busy, 0);
    chk("t6_line_idle", cnt_low, 0);
    start = 1'b0;
    @(negedge clock);
    data = 32'hBADC0FFE;
    push_word(data);
    pulse_start();
    chk("t6_new_edge_busy", {31'h0, busy}, 32'h1);
    run_until_done(bc);
    @(negedge clock);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
